// File: rtl/input_vc_buffer_pkg.sv
// ---------------------------------------------------------------------------
// input_vc_buffer_pkg
//
// Purpose:
//    Shared types and constants for the router input VC buffer slice.
//    Holds the default sizing of one input port, the flit type encoding
//    carried in the top two bits of every flit, the per-VC packet state
//    encoding, and small helpers that classify a flit type.
//
// Contents:
//    NUM_PORTS / NUM_VC / BUF_DEPTH / FLIT_WIDTH  default sizing
//    TYPE_BITS                                    width of the type field
//    flit_type_e                                  BODY/HEAD/TAIL/HEAD_TAIL
//    vc_state_e                                   IDLE/VC_ALLOC/ACTIVE
//    isHeadType / isTailType                      flit type classifiers
// ---------------------------------------------------------------------------
package input_vc_buffer_pkg;

   localparam int NUM_PORTS  = 5;
   localparam int NUM_VC     = 4;
   localparam int BUF_DEPTH  = 4;
   localparam int FLIT_WIDTH = 32;

   // The flit type lives in the most significant TYPE_BITS of the flit,
   // i.e. bits [FLIT_WIDTH-1 : FLIT_WIDTH-TYPE_BITS].
   localparam int TYPE_BITS  = 2;

   typedef enum logic [1:0] {
      BODY      = 2'b00,
      HEAD      = 2'b01,
      TAIL      = 2'b10,
      HEAD_TAIL = 2'b11
   } flit_type_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      VC_ALLOC = 2'd1,
      ACTIVE   = 2'd2
   } vc_state_e;

   // A flit opens a packet when it is a HEAD or a single-flit HEAD_TAIL.
   function automatic logic isHeadType(input flit_type_e flitType);
      return (flitType == HEAD) || (flitType == HEAD_TAIL);
   endfunction

   // A flit closes a packet when it is a TAIL or a single-flit HEAD_TAIL.
   function automatic logic isTailType(input flit_type_e flitType);
      return (flitType == TAIL) || (flitType == HEAD_TAIL);
   endfunction

endpackage

// File: rtl/input_vc_buffer_if.sv
// ---------------------------------------------------------------------------
// input_vc_buffer_if
//
// Purpose:
//    Bundles every non-clock, non-reset signal of one router input port
//    buffer. The "slave" modport is the buffer itself; the "master"
//    modport is whatever surrounds it (upstream link, VC allocator,
//    switch stage).
//
// Signals:
//    flit_in_valid / flit_in / flit_in_vc   flit write from upstream
//    vc_req / dst_port                      request and route to the VA
//    vc_grant / vc_grant_id                 VA grant and granted output VC
//    sa_req                                 switch request per VC
//    rd_valid / rd_vc                       switch-stage dequeue
//    flit_out / flit_out_ovc                head flit and output VC of rd_vc
//    credit_valid / credit_vc               credit return upstream
//    err_overflow / err_underflow           sticky error flags
// ---------------------------------------------------------------------------
interface input_vc_buffer_if #(
   parameter int NUM_PORTS  = 5,
   parameter int NUM_VC     = 4,
   parameter int FLIT_WIDTH = 32
);

   localparam int VC_BITS = $clog2(NUM_VC);

   logic                                flit_in_valid;
   logic [FLIT_WIDTH-1:0]               flit_in;
   logic [VC_BITS-1:0]                  flit_in_vc;

   logic [NUM_VC-1:0]                   vc_req;
   logic [NUM_VC-1:0][NUM_PORTS-1:0]    dst_port;
   logic [NUM_VC-1:0]                   vc_grant;
   logic [NUM_VC-1:0][VC_BITS-1:0]      vc_grant_id;

   logic [NUM_VC-1:0]                   sa_req;
   logic                                rd_valid;
   logic [VC_BITS-1:0]                  rd_vc;
   logic [FLIT_WIDTH-1:0]               flit_out;
   logic [VC_BITS-1:0]                  flit_out_ovc;

   logic                                credit_valid;
   logic [VC_BITS-1:0]                  credit_vc;

   logic                                err_overflow;
   logic                                err_underflow;

   // The buffer receives flits, grants and dequeue strobes and drives
   // everything else.
   modport slave (
      input  flit_in_valid, flit_in, flit_in_vc,
      input  vc_grant, vc_grant_id,
      input  rd_valid, rd_vc,
      output vc_req, dst_port, sa_req,
      output flit_out, flit_out_ovc,
      output credit_valid, credit_vc,
      output err_overflow, err_underflow
   );

   // The router side is the mirror image of the buffer.
   modport master (
      output flit_in_valid, flit_in, flit_in_vc,
      output vc_grant, vc_grant_id,
      output rd_valid, rd_vc,
      input  vc_req, dst_port, sa_req,
      input  flit_out, flit_out_ovc,
      input  credit_valid, credit_vc,
      input  err_overflow, err_underflow
   );

endinterface

// File: rtl/input_vc_buffer_vc_fifo.sv
// ---------------------------------------------------------------------------
// input_vc_buffer_vc_fifo
//
// Purpose:
//    Single-clock FIFO holding the flits of one virtual channel. The head
//    entry is always presented combinationally so the owner can inspect
//    the flit type and route before deciding to pop.
//
// Ports:
//    clk      in   clock
//    reset    in   synchronous, active-low reset (empties the FIFO)
//    i_push   in   write request; honoured when not full or when popping
//    i_data   in   flit to write
//    i_pop    in   read request; ignored when empty
//    o_head   out  flit at the read pointer
//    o_full   out  DEPTH entries stored
//    o_empty  out  no entries stored
// ---------------------------------------------------------------------------
module input_vc_buffer_vc_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [PTR_BITS-1:0] r_wrPtr;
   logic [PTR_BITS-1:0] r_rdPtr;
   logic [CNT_BITS-1:0] r_count;

   logic                w_doPop;
   logic                w_doPush;

   // A pop needs something to pop. A push into a full FIFO is still
   // accepted when the same edge pops, because a slot frees up at that
   // edge and the occupancy simply stays at DEPTH.
   assign w_doPop  = i_pop && !o_empty;
   assign w_doPush = i_push && (!o_full || w_doPop);

   assign o_full   = (r_count == CNT_BITS'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign o_head   = r_mem[r_rdPtr];

   // Pointer and occupancy bookkeeping. Pointers are exactly PTR_BITS wide
   // so they wrap modulo DEPTH on their own (DEPTH is a power of two).
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array. It carries no reset: stale contents are unreachable
   // once the pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

endmodule

// File: rtl/input_vc_buffer.sv
// ---------------------------------------------------------------------------
// input_vc_buffer
//
// Purpose:
//    Buffering and VC state stage for one router input port. Incoming
//    flits are stored in NUM_VC independent FIFOs. Each VC runs a small
//    packet FSM (IDLE -> VC_ALLOC -> ACTIVE -> IDLE): a head flit at the
//    FIFO front latches its one-hot route and requests an output VC; a
//    grant latches the output VC and moves the VC to ACTIVE, where it
//    requests the switch while it holds flits. Dequeues from the switch
//    stage (and discards of stray non-head flits) return a credit
//    upstream one cycle later.
//
// Ports:
//    clk    in   clock
//    reset  in   synchronous, active-low reset
//    bus    slave modport of input_vc_buffer_if:
//           flit_in_valid/flit_in/flit_in_vc   flit write
//           vc_req/dst_port                    VA request and route per VC
//           vc_grant/vc_grant_id               VA grant per VC
//           sa_req                             switch request per VC
//           rd_valid/rd_vc                     dequeue strobe and VC
//           flit_out/flit_out_ovc              head flit and ovc of rd_vc
//           credit_valid/credit_vc             one-cycle credit pulse
//           err_overflow/err_underflow         sticky error flags
// ---------------------------------------------------------------------------
module input_vc_buffer
   import input_vc_buffer_pkg::*;
#(
   parameter int NUM_PORTS  = input_vc_buffer_pkg::NUM_PORTS,
   parameter int NUM_VC     = input_vc_buffer_pkg::NUM_VC,
   parameter int BUF_DEPTH  = input_vc_buffer_pkg::BUF_DEPTH,
   parameter int FLIT_WIDTH = input_vc_buffer_pkg::FLIT_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input_vc_buffer_if.slave   bus
);

   localparam int VC_BITS = $clog2(NUM_VC);

   logic [FLIT_WIDTH-1:0]            w_fifoHead [NUM_VC];
   logic [NUM_VC-1:0]                w_full;
   logic [NUM_VC-1:0]                w_empty;
   logic [NUM_VC-1:0]                w_push;
   logic [NUM_VC-1:0]                w_pop;

   flit_type_e                       w_headType [NUM_VC];
   logic [NUM_VC-1:0]                w_headIsHead;
   logic [NUM_VC-1:0]                w_headIsTail;

   vc_state_e                        r_vcState  [NUM_VC];
   vc_state_e                        w_nextState [NUM_VC];
   logic [NUM_VC-1:0]                w_latchDst;
   logic [NUM_VC-1:0]                w_latchOvc;

   logic [NUM_VC-1:0][NUM_PORTS-1:0] r_dstPort;
   logic [NUM_VC-1:0][VC_BITS-1:0]   r_ovc;

   logic                             w_rdHit;
   logic                             w_rdBad;
   logic                             w_discardHit;
   logic [VC_BITS-1:0]               w_discardVc;
   logic                             w_overflowHit;

   logic                             r_creditValid;
   logic [VC_BITS-1:0]               r_creditVc;
   logic                             r_errOverflow;
   logic                             r_errUnderflow;

   // One FIFO per virtual channel. Each FIFO decides on its own whether a
   // push fits, which lets a full FIFO take a write on the cycle it pops.
   for (genvar g = 0; g < NUM_VC; g++) begin : gVcFifo
      input_vc_buffer_vc_fifo #(
         .DEPTH (BUF_DEPTH),
         .WIDTH (FLIT_WIDTH)
      ) uFifo (
         .clk     (clk),
         .reset   (reset),
         .i_push  (w_push[g]),
         .i_data  (bus.flit_in),
         .i_pop   (w_pop[g]),
         .o_head  (w_fifoHead[g]),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g])
      );
   end

   // Classify the flit sitting at the front of every FIFO. The FSM only
   // looks at these when the FIFO is non-empty.
   always_comb begin
      w_headIsHead = '0;
      w_headIsTail = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         w_headType[v]   = flit_type_e'(w_fifoHead[v][FLIT_WIDTH-1 -: TYPE_BITS]);
         w_headIsHead[v] = isHeadType(w_headType[v]);
         w_headIsTail[v] = isTailType(w_headType[v]);
      end
   end

   // Dequeue qualification. A read only pops from an ACTIVE VC that holds
   // a flit; anything else is an underflow and leaves the FIFO alone, even
   // if a write to that VC lands on the same edge.
   always_comb begin
      w_rdHit = bus.rd_valid && (r_vcState[bus.rd_vc] == ACTIVE) && !w_empty[bus.rd_vc];
      w_rdBad = bus.rd_valid && !w_rdHit;
   end

   // A non-head flit at the front of an IDLE VC cannot belong to any
   // packet, so it is thrown away and its slot credited back. Only one pop
   // per cycle is allowed so that a single credit port suffices: a real
   // dequeue wins, and among stray flits the lowest VC goes first. Any
   // other stray flit simply waits in its IDLE VC for a later cycle.
   always_comb begin
      w_discardHit = 1'b0;
      w_discardVc  = '0;
      if (!w_rdHit) begin
         for (int v = 0; v < NUM_VC; v++) begin
            if (!w_discardHit && (r_vcState[v] == IDLE) && !w_empty[v] && !w_headIsHead[v]) begin
               w_discardHit = 1'b1;
               w_discardVc  = VC_BITS'(v);
            end
         end
      end
   end

   // Per-VC push/pop strobes and overflow detection. A write to a full VC
   // is only an overflow when that VC is not popping on the same edge.
   always_comb begin
      w_push        = '0;
      w_pop         = '0;
      w_overflowHit = 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
         w_push[v] = bus.flit_in_valid && (bus.flit_in_vc == VC_BITS'(v));
         w_pop[v]  = (w_rdHit && (bus.rd_vc == VC_BITS'(v))) ||
                     (w_discardHit && (w_discardVc == VC_BITS'(v)));
         if (w_push[v] && w_full[v] && !w_pop[v]) begin
            w_overflowHit = 1'b1;
         end
      end
   end

   // Next-state logic of the per-VC packet FSM. A VC that pops its tail
   // goes back to IDLE and only looks at the next head one edge later,
   // which gives a fixed one-cycle bubble between packets on a VC.
   always_comb begin
      w_latchDst = '0;
      w_latchOvc = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         w_nextState[v] = r_vcState[v];
         case (r_vcState[v])
            IDLE: begin
               if (!w_empty[v] && w_headIsHead[v]) begin
                  w_nextState[v] = VC_ALLOC;
                  w_latchDst[v]  = 1'b1;
               end
            end
            VC_ALLOC: begin
               if (bus.vc_grant[v]) begin
                  w_nextState[v] = ACTIVE;
                  w_latchOvc[v]  = 1'b1;
               end
            end
            ACTIVE: begin
               if (w_pop[v] && w_headIsTail[v]) begin
                  w_nextState[v] = IDLE;
               end
            end
            default: begin
               w_nextState[v] = IDLE;
            end
         endcase
      end
   end

   // Packet state, latched route and output VC. The route and output VC
   // are only overwritten by the next head/grant, so they stay readable
   // after the packet has left.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int v = 0; v < NUM_VC; v++) begin
            r_vcState[v] <= IDLE;
         end
         r_dstPort <= '0;
         r_ovc     <= '0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            r_vcState[v] <= w_nextState[v];
            if (w_latchDst[v]) begin
               r_dstPort[v] <= w_fifoHead[v][NUM_PORTS-1:0];
            end
            if (w_latchOvc[v]) begin
               r_ovc[v] <= bus.vc_grant_id[v];
            end
         end
      end
   end

   // Credit return and sticky error flags. Each pop, whether a dequeue or
   // a discard, yields a single-cycle credit pulse on the next cycle.
   // Reset clears the pulse, so flits flushed by reset are never credited.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_creditValid  <= 1'b0;
         r_creditVc     <= '0;
         r_errOverflow  <= 1'b0;
         r_errUnderflow <= 1'b0;
      end else begin
         r_creditValid  <= |w_pop;
         r_creditVc     <= w_rdHit ? bus.rd_vc : w_discardVc;
         r_errOverflow  <= r_errOverflow | w_overflowHit;
         r_errUnderflow <= r_errUnderflow | w_rdBad | w_discardHit;
      end
   end

   // Request vectors toward the VC and switch allocators.
   always_comb begin
      bus.vc_req = '0;
      bus.sa_req = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         bus.vc_req[v] = (r_vcState[v] == VC_ALLOC);
         bus.sa_req[v] = (r_vcState[v] == ACTIVE) && !w_empty[v];
      end
   end

   // The switch stage sees the head of the VC it addresses in the same
   // cycle, so flit_out is a plain mux on rd_vc.
   assign bus.dst_port      = r_dstPort;
   assign bus.flit_out      = w_fifoHead[bus.rd_vc];
   assign bus.flit_out_ovc  = r_ovc[bus.rd_vc];
   assign bus.credit_valid  = r_creditValid;
   assign bus.credit_vc     = r_creditVc;
   assign bus.err_overflow  = r_errOverflow;
   assign bus.err_underflow = r_errUnderflow;

endmodule

// File: tb/tb_input_vc_buffer.sv
// ---------------------------------------------------------------------------
// tb_input_vc_buffer
//
// Purpose:
//    Self-checking bench for input_vc_buffer. Directed stimulus pushes the
//    expected dequeued flits and credits into scoreboard queues; a monitor
//    on the falling clock edge pops and compares them whenever the DUT
//    presents a dequeue or a credit pulse. State outputs (requests, routes,
//    error flags) are spot-checked after the relevant edges.
// ---------------------------------------------------------------------------
module tb_input_vc_buffer;
   import input_vc_buffer_pkg::*;

   typedef struct {
      logic [31:0] flit;
      logic [1:0]  ovc;
   } rdExp_t;

   typedef struct {
      logic [1:0] vc;
      int         cycle;
   } credExp_t;

   logic     clk;
   logic     reset;
   int       cyc = 0;
   int       checks = 0;
   int       failures = 0;
   logic     rdCheck;
   rdExp_t   readQ[$];
   credExp_t credQ[$];

   input_vc_buffer_if #(
      .NUM_PORTS  (NUM_PORTS),
      .NUM_VC     (NUM_VC),
      .FLIT_WIDTH (FLIT_WIDTH)
   ) bus ();

   input_vc_buffer #(
      .NUM_PORTS  (NUM_PORTS),
      .NUM_VC     (NUM_VC),
      .BUF_DEPTH  (BUF_DEPTH),
      .FLIT_WIDTH (FLIT_WIDTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // 10-unit clock; rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index used to time-stamp expected credit pulses.
   always @(posedge clk) cyc <= cyc + 1;

   // Compare one observed value with its required value.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: compare dequeued flits and credit pulses against the queues.
   always @(negedge clk) begin
      rdExp_t   re;
      credExp_t ce;
      if (bus.rd_valid && rdCheck) begin
         if (readQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL read_unexpected actual=%h required=none", bus.flit_out);
         end else begin
            re = readQ.pop_front();
            checkOutput("flit_out", bus.flit_out, re.flit);
            checkOutput("flit_out_ovc", 32'(bus.flit_out_ovc), 32'(re.ovc));
         end
      end
      if (bus.credit_valid === 1'b1) begin
         if (credQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL credit_unexpected actual=vc%0d required=no_credit (cycle %0d)", bus.credit_vc, cyc);
         end else begin
            ce = credQ.pop_front();
            checkOutput("credit_vc", 32'(bus.credit_vc), 32'(ce.vc));
            checkOutput("credit_cycle", 32'(cyc), 32'(ce.cycle));
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one cycle of write and/or read; a checked read queues the
   // expected flit and the credit due on the following cycle.
   task automatic applyStimulus(input logic wrEn, input logic [31:0] wrFlit, input logic [1:0] wrVc,
                                input logic rdEn, input logic [1:0] rdVc, input logic expRd,
                                input logic [31:0] expFlit, input logic [1:0] expOvc);
      rdExp_t   re;
      credExp_t ce;
      bus.flit_in_valid = wrEn;
      bus.flit_in       = wrFlit;
      bus.flit_in_vc    = wrVc;
      bus.rd_valid      = rdEn;
      bus.rd_vc         = rdVc;
      rdCheck           = expRd;
      if (expRd) begin
         re.flit = expFlit;
         re.ovc  = expOvc;
         readQ.push_back(re);
         ce.vc    = rdVc;
         ce.cycle = cyc + 1;
         credQ.push_back(ce);
      end
      tick(1);
      bus.flit_in_valid = 1'b0;
      bus.rd_valid      = 1'b0;
      rdCheck           = 1'b0;
   endtask

   task automatic writeFlit(input logic [31:0] flit, input logic [1:0] vc);
      applyStimulus(1'b1, flit, vc, 1'b0, 2'd0, 1'b0, 32'h0, 2'd0);
   endtask

   task automatic readFlit(input logic [1:0] vc, input logic [31:0] expFlit, input logic [1:0] expOvc);
      applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, vc, 1'b1, expFlit, expOvc);
   endtask

   task automatic grantVc(input int vc, input logic [1:0] id);
      bus.vc_grant[vc]    = 1'b1;
      bus.vc_grant_id[vc] = id;
      tick(1);
      bus.vc_grant = '0;
   endtask

   initial begin
      credExp_t ce;
      reset             = 1'b0;
      rdCheck           = 1'b0;
      bus.flit_in_valid = 1'b0;
      bus.flit_in       = '0;
      bus.flit_in_vc    = '0;
      bus.vc_grant      = '0;
      bus.vc_grant_id   = '0;
      bus.rd_valid      = 1'b0;
      bus.rd_vc         = '0;
      tick(2);
      reset = 1'b1;

      $display("[TB] reset state");
      checkOutput("rst_vc_req", 32'(bus.vc_req), 32'h0);
      checkOutput("rst_sa_req", 32'(bus.sa_req), 32'h0);
      checkOutput("rst_credit_valid", 32'(bus.credit_valid), 32'h0);
      checkOutput("rst_err_overflow", 32'(bus.err_overflow), 32'h0);
      checkOutput("rst_err_underflow", 32'(bus.err_underflow), 32'h0);
      checkOutput("rst_dst_port", 32'(bus.dst_port), 32'h0);

      $display("[TB] single HEAD_TAIL on VC2");
      writeFlit(32'hC0AB_C004, 2'd2);
      checkOutput("t1_vc_req_wait", 32'(bus.vc_req), 32'h0);
      tick(1);
      checkOutput("t1_vc_req", 32'(bus.vc_req), 32'h4);
      checkOutput("t1_dst_port2", 32'(bus.dst_port[2]), 32'h04);
      grantVc(2, 2'd3);
      checkOutput("t1_sa_req", 32'(bus.sa_req), 32'h4);
      checkOutput("t1_vc_req_after_grant", 32'(bus.vc_req), 32'h0);
      readFlit(2'd2, 32'hC0AB_C004, 2'd3);
      checkOutput("t1_sa_req_idle", 32'(bus.sa_req), 32'h0);
      checkOutput("t1_vc_req_idle", 32'(bus.vc_req), 32'h0);
      tick(2);

      $display("[TB] tail pop with next head queued on VC1");
      writeFlit(32'hC000_0002, 2'd1);
      writeFlit(32'h4000_0008, 2'd1);
      writeFlit(32'h8000_5555, 2'd1);
      checkOutput("t3_vc_req", 32'(bus.vc_req), 32'h2);
      checkOutput("t3_dst_port1_a", 32'(bus.dst_port[1]), 32'h02);
      grantVc(1, 2'd2);
      readFlit(2'd1, 32'hC000_0002, 2'd2);
      checkOutput("t3_bubble_vc_req", 32'(bus.vc_req), 32'h0);
      checkOutput("t3_bubble_sa_req", 32'(bus.sa_req), 32'h0);
      tick(1);
      checkOutput("t3_vc_req_next", 32'(bus.vc_req), 32'h2);
      checkOutput("t3_dst_port1_b", 32'(bus.dst_port[1]), 32'h08);
      grantVc(1, 2'd1);
      readFlit(2'd1, 32'h4000_0008, 2'd1);
      checkOutput("t3_sa_req_mid", 32'(bus.sa_req), 32'h2);
      readFlit(2'd1, 32'h8000_5555, 2'd1);
      checkOutput("t3_sa_req_end", 32'(bus.sa_req), 32'h0);
      tick(2);

      $display("[TB] write and read on full VC3");
      writeFlit(32'h4000_0010, 2'd3);
      writeFlit(32'h0000_AAAA, 2'd3);
      writeFlit(32'h0000_BBBB, 2'd3);
      writeFlit(32'h0000_CCCC, 2'd3);
      grantVc(3, 2'd0);
      checkOutput("t4_sa_req", 32'(bus.sa_req), 32'h8);
      applyStimulus(1'b1, 32'h8000_DDDD, 2'd3, 1'b1, 2'd3, 1'b1, 32'h4000_0010, 2'd0);
      checkOutput("t4_err_overflow", 32'(bus.err_overflow), 32'h0);
      readFlit(2'd3, 32'h0000_AAAA, 2'd0);
      readFlit(2'd3, 32'h0000_BBBB, 2'd0);
      readFlit(2'd3, 32'h0000_CCCC, 2'd0);
      readFlit(2'd3, 32'h8000_DDDD, 2'd0);
      checkOutput("t4_sa_req_end", 32'(bus.sa_req), 32'h0);
      tick(2);

      $display("[TB] overflow on VC0");
      writeFlit(32'h4000_0001, 2'd0);
      writeFlit(32'h0000_1111, 2'd0);
      writeFlit(32'h0000_2222, 2'd0);
      writeFlit(32'h8000_3333, 2'd0);
      checkOutput("t2_err_overflow_before", 32'(bus.err_overflow), 32'h0);
      writeFlit(32'h0000_4444, 2'd0);
      checkOutput("t2_err_overflow", 32'(bus.err_overflow), 32'h1);
      grantVc(0, 2'd1);
      readFlit(2'd0, 32'h4000_0001, 2'd1);
      readFlit(2'd0, 32'h0000_1111, 2'd1);
      readFlit(2'd0, 32'h0000_2222, 2'd1);
      readFlit(2'd0, 32'h8000_3333, 2'd1);
      tick(2);
      checkOutput("t2_vc_req_empty", 32'(bus.vc_req), 32'h0);
      checkOutput("t2_sa_req_empty", 32'(bus.sa_req), 32'h0);
      checkOutput("t2_err_underflow", 32'(bus.err_underflow), 32'h0);

      $display("[TB] read of VC0 while in VC_ALLOC");
      writeFlit(32'h4000_0004, 2'd0);
      tick(1);
      checkOutput("t5_vc_req", 32'(bus.vc_req), 32'h1);
      applyStimulus(1'b0, 32'h0, 2'd0, 1'b1, 2'd0, 1'b0, 32'h0, 2'd0);
      checkOutput("t5_err_underflow", 32'(bus.err_underflow), 32'h1);
      checkOutput("t5_vc_req_hold", 32'(bus.vc_req), 32'h1);
      tick(2);

      $display("[TB] reset mid-packet on VC1");
      writeFlit(32'h4000_0001, 2'd1);
      writeFlit(32'h0000_9999, 2'd1);
      grantVc(1, 2'd2);
      checkOutput("t6_sa_req_before", 32'(bus.sa_req), 32'h2);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      checkOutput("t6_vc_req", 32'(bus.vc_req), 32'h0);
      checkOutput("t6_sa_req", 32'(bus.sa_req), 32'h0);
      checkOutput("t6_credit_valid", 32'(bus.credit_valid), 32'h0);
      checkOutput("t6_err_underflow", 32'(bus.err_underflow), 32'h0);
      checkOutput("t6_err_overflow", 32'(bus.err_overflow), 32'h0);
      checkOutput("t6_dst_port", 32'(bus.dst_port), 32'h0);
      writeFlit(32'hC000_0008, 2'd1);
      tick(1);
      checkOutput("t6_vc_req_new", 32'(bus.vc_req), 32'h2);
      checkOutput("t6_dst_port1", 32'(bus.dst_port[1]), 32'h08);
      grantVc(1, 2'd3);
      readFlit(2'd1, 32'hC000_0008, 2'd3);
      tick(2);

      $display("[TB] stray BODY on idle VC3");
      ce.vc    = 2'd3;
      ce.cycle = cyc + 2;
      credQ.push_back(ce);
      writeFlit(32'h0000_7777, 2'd3);
      checkOutput("t7_err_underflow_before", 32'(bus.err_underflow), 32'h0);
      tick(1);
      checkOutput("t7_err_underflow", 32'(bus.err_underflow), 32'h1);
      checkOutput("t7_vc_req", 32'(bus.vc_req), 32'h0);
      checkOutput("t7_sa_req", 32'(bus.sa_req), 32'h0);
      tick(3);

      checkOutput("credits_outstanding", 32'(credQ.size()), 32'h0);
      checkOutput("reads_outstanding", 32'(readQ.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
